// File: rtl/p4_router_ingress_dwrr_sched.sv
// p4_router_ingress_dwrr_sched
// Deficit-weighted round-robin scheduler for the ingress buffer read side.
// Picks which ingress partition sends its next complete packet toward VNP4.
// Each visit credits a port with its quantum. The port is then granted packets
// while its head packet fits in the accumulated deficit.
//
// Ports:
//   i_clk, i_areset        clock, asynchronous active-high reset
//   i_pkt_avail[p]         partition p holds at least one complete packet
//   i_head_len             head packet byte length, port p at [p*LEN_W +: LEN_W]
//   i_quantum              bytes credited per visit, port p at [p*QUANTUM_WIDTH +: ...]
//   o_grant_valid/i_grant_ready  grant handshake toward the read controller
//   o_grant_port, o_grant_bytes  granted partition and its head packet length
//   i_pkt_done             one-cycle pulse, granted packet fully read out
//   o_grant_cnt            accepted grants per port, 32 bits each
//
// Optional feature macro: P4_ROUTER_ING_SCHED_STATS_EN.
// When it is defined, o_grant_cnt holds live per-port counters.
// When it is undefined, o_grant_cnt is tied to zero and no counters are built.

module p4_router_ingress_dwrr_sched #(
  parameter int NUM_PORTS     = 4,
  parameter int MTU_BYTES     = 1500,
  parameter int QUANTUM_WIDTH = 12,
  parameter int DEFICIT_WIDTH = 13,
  parameter int LEN_W         = $clog2(MTU_BYTES) + 1,
  parameter int PORT_W        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                               i_clk,
  input  logic                               i_areset,
  input  logic [NUM_PORTS-1:0]               i_pkt_avail,
  input  logic [NUM_PORTS*LEN_W-1:0]         i_head_len,
  input  logic [NUM_PORTS*QUANTUM_WIDTH-1:0] i_quantum,
  output logic                               o_grant_valid,
  input  logic                               i_grant_ready,
  output logic [PORT_W-1:0]                  o_grant_port,
  output logic [LEN_W-1:0]                   o_grant_bytes,
  input  logic                               i_pkt_done,
  output logic [NUM_PORTS*32-1:0]            o_grant_cnt
);

  if (DEFICIT_WIDTH < LEN_W) begin : g_width_check
    $error("DEFICIT_WIDTH must be at least LEN_W");
  end

  localparam logic [1:0] S_ADD   = 2'd0;
  localparam logic [1:0] S_EVAL  = 2'd1;
  localparam logic [1:0] S_GRANT = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  localparam int SUM_W = ((DEFICIT_WIDTH > QUANTUM_WIDTH) ? DEFICIT_WIDTH : QUANTUM_WIDTH) + 1;
  localparam logic [DEFICIT_WIDTH-1:0] DEF_MAX = '1;

  logic [1:0]               r_state;
  logic [PORT_W-1:0]        r_cur;
  logic [DEFICIT_WIDTH-1:0] r_deficit [NUM_PORTS];

  logic [LEN_W-1:0]         w_cur_len;
  logic [QUANTUM_WIDTH-1:0] w_cur_q;
  logic [DEFICIT_WIDTH-1:0] w_cur_def;
  logic [SUM_W-1:0]         w_sum;
  logic [DEFICIT_WIDTH-1:0] w_def_sat;
  logic                     w_fits;
  logic [PORT_W-1:0]        w_next_cur;
  logic                     w_accept;

  assign w_cur_len  = i_head_len[int'(r_cur)*LEN_W +: LEN_W];
  assign w_cur_q    = i_quantum[int'(r_cur)*QUANTUM_WIDTH +: QUANTUM_WIDTH];
  assign w_cur_def  = r_deficit[r_cur];
  // The sum is one bit wider than either operand, so the overflow check sees the carry.
  assign w_sum      = SUM_W'(w_cur_def) + SUM_W'(w_cur_q);
  assign w_def_sat  = (w_sum > SUM_W'(DEF_MAX)) ? DEF_MAX : w_sum[DEFICIT_WIDTH-1:0];
  assign w_fits     = DEFICIT_WIDTH'(w_cur_len) <= w_cur_def;
  assign w_next_cur = (r_cur == PORT_W'(NUM_PORTS-1)) ? '0 : r_cur + 1'b1;
  assign w_accept   = o_grant_valid && i_grant_ready;

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      r_state       <= S_ADD;
      r_cur         <= '0;
      o_grant_valid <= 1'b0;
      o_grant_port  <= '0;
      o_grant_bytes <= '0;
      for (int p = 0; p < NUM_PORTS; p++) r_deficit[p] <= '0;
    end else begin
      case (r_state)
        S_ADD: begin
          if (i_pkt_avail[r_cur]) begin
            r_deficit[r_cur] <= w_def_sat;
            r_state          <= S_EVAL;
          end else begin
            r_deficit[r_cur] <= '0;
            r_cur            <= w_next_cur;
          end
        end
        S_EVAL: begin
          if (i_pkt_avail[r_cur] && w_fits) begin
            o_grant_valid <= 1'b1;
            o_grant_port  <= r_cur;
            o_grant_bytes <= w_cur_len;
            r_state       <= S_GRANT;
          end else begin
            if (!i_pkt_avail[r_cur]) r_deficit[r_cur] <= '0;
            r_cur   <= w_next_cur;
            r_state <= S_ADD;
          end
        end
        S_GRANT: begin
          if (w_accept) begin
            // A grant was only issued when the packet fitted, so this subtraction cannot underflow.
            r_deficit[r_cur] <= w_cur_def - DEFICIT_WIDTH'(o_grant_bytes);
            o_grant_valid    <= 1'b0;
            r_state          <= S_WAIT;
          end
        end
        default: begin
          // Return to S_EVAL without a new credit, so a port drains its deficit before the scan moves on.
          if (i_pkt_done) r_state <= S_EVAL;
        end
      endcase
    end
  end

`ifdef P4_ROUTER_ING_SCHED_STATS_EN
  logic [31:0] r_grant_cnt [NUM_PORTS];

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      for (int p = 0; p < NUM_PORTS; p++) r_grant_cnt[p] <= '0;
    end else if (w_accept) begin
      r_grant_cnt[o_grant_port] <= r_grant_cnt[o_grant_port] + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt_out
    assign o_grant_cnt[g*32 +: 32] = r_grant_cnt[g];
  end
`else
  assign o_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_p4_router_ingress_dwrr_sched.sv
module tb_p4_router_ingress_dwrr_sched;

  localparam int NP = 4;
  localparam int LW = 12;
  localparam int QW = 12;

  logic            clk;
  logic            areset;
  logic [NP-1:0]   pkt_avail;
  logic [NP*LW-1:0] head_len;
  logic [NP*QW-1:0] quantum;
  logic            grant_valid;
  logic            grant_ready;
  logic [1:0]      grant_port;
  logic [LW-1:0]   grant_bytes;
  logic            pkt_done;
  logic [NP*32-1:0] grant_cnt;

  p4_router_ingress_dwrr_sched dut (
    .i_clk         (clk),
    .i_areset      (areset),
    .i_pkt_avail   (pkt_avail),
    .i_head_len    (head_len),
    .i_quantum     (quantum),
    .o_grant_valid (grant_valid),
    .i_grant_ready (grant_ready),
    .o_grant_port  (grant_port),
    .o_grant_bytes (grant_bytes),
    .i_pkt_done    (pkt_done),
    .o_grant_cnt   (grant_cnt)
  );

  typedef struct packed {
    logic [1:0]    port;
    logic [LW-1:0] bytes;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   acc_cnt  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted grant pops one expected entry.
  always @(negedge clk) begin
    if (!areset && grant_valid && grant_ready) begin
      acc_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_grant_port", int'(grant_port), -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("grant_port", int'(grant_port), int'(e.port));
        chk("grant_bytes", int'(grant_bytes), int'(e.bytes));
      end
    end
  end

  // Read-controller model: pulses pkt_done one cycle after each acceptance.
  initial begin
    pkt_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!areset && grant_valid && grant_ready) begin
        @(posedge clk);
        @(negedge clk);
        pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
      end
    end
  end

  task automatic push_exp(input int p, input int b);
    exp_t e;
    e.port  = 2'(p);
    e.bytes = LW'(b);
    exp_q.push_back(e);
  endtask

  task automatic clear_cfg();
    pkt_avail = '0;
    head_len  = '0;
    quantum   = '0;
  endtask

  task automatic set_port(input int p, input logic av, input int q, input int len);
    pkt_avail[p]       = av;
    quantum[p*QW +: QW] = QW'(q);
    head_len[p*LW +: LW] = LW'(len);
  endtask

  task automatic enter_reset();
    areset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1 areset = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int n);
    int k;
    k = 0;
    while (acc_cnt < n && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (acc_cnt < n) chk("accept_timeout", acc_cnt, n);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!grant_valid && n < 200);
    if (!grant_valid) chk("valid_timeout", 0, 1);
  endtask

  initial begin
    int n;
    int base;
    areset      = 1'b1;
    grant_ready = 1'b0;
    clear_cfg();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(grant_valid), 0);
    chk("rst_port", int'(grant_port), 0);
    chk("rst_bytes", int'(grant_bytes), 0);
    chk("rst_cnt_zero", int'(grant_cnt == '0), 1);

    // Port 0 only: quantum 1500, len 64.
    set_port(0, 1'b1, 1500, 64);
    grant_ready = 1'b1;
    base = acc_cnt;
    repeat (3) push_exp(0, 64);
    release_rst();
    tick(1);
    chk("lat_cycle1_valid", int'(grant_valid), 0);
    tick(1);
    chk("lat_cycle2_valid", int'(grant_valid), 1);
    chk("lat_port", int'(grant_port), 0);
    chk("lat_bytes", int'(grant_bytes), 64);
    wait_acc(base + 1);
    chk("deficit_after_accept", int'(dut.r_deficit[0]), 1436);
    tick(1);
    chk("eval_gap_valid", int'(grant_valid), 0);
    tick(1);
    chk("regrant_valid", int'(grant_valid), 1);
    wait_acc(base + 3);
`ifdef P4_ROUTER_ING_SCHED_STATS_EN
    chk("stats_p0_cnt", int'(grant_cnt[31:0]), 3);
`endif
    areset = 1'b1;
    #1;
    chk("wait_rst_deficit0", int'(dut.r_deficit[0]), 0);
    chk("wait_rst_cnt_zero", int'(grant_cnt == '0), 1);
    chk("wait_rst_valid", int'(grant_valid), 0);
    repeat (2) @(posedge clk);

    // Ports 0 and 1: quantum 1500, lengths 1500 and 64.
    clear_cfg();
    set_port(0, 1'b1, 1500, 1500);
    set_port(1, 1'b1, 1500, 64);
    base = acc_cnt;
    push_exp(0, 1500);
    repeat (23) push_exp(1, 64);
    push_exp(0, 1500);
    release_rst();
    wait_acc(base + 24);
    chk("p1_residual", int'(dut.r_deficit[1]), 28);
`ifdef P4_ROUTER_ING_SCHED_STATS_EN
    chk("stats_round_p0", int'(grant_cnt[31:0]), 1);
    chk("stats_round_p1", int'(grant_cnt[63:32]), 23);
`endif
    areset = 1'b1;
    #1;
    chk("rst_deficit1", int'(dut.r_deficit[1]), 0);
    repeat (2) @(posedge clk);
    release_rst();
    wait_acc(base + 25);
    enter_reset();

    // Port 0 alone, quantum 500, len 1500: granted on the third visit.
    clear_cfg();
    set_port(0, 1'b1, 500, 1500);
    base = acc_cnt;
    push_exp(0, 1500);
    release_rst();
    wait_valid(n);
    chk("third_visit_edges", n, 12);
    wait_acc(base + 1);
    chk("q500_deficit", int'(dut.r_deficit[0]), 0);
    enter_reset();

    // Port 1 drops avail while its deficit is 700.
    clear_cfg();
    set_port(1, 1'b1, 700, 800);
    base = acc_cnt;
    push_exp(1, 800);
    release_rst();
    tick(3);
    chk("p1_def_700", int'(dut.r_deficit[1]), 700);
    pkt_avail[1] = 1'b0;
    tick(4);
    chk("p1_def_cleared", int'(dut.r_deficit[1]), 0);
    pkt_avail[1] = 1'b1;
    tick(4);
    chk("p1_def_restart", int'(dut.r_deficit[1]), 700);
    wait_acc(base + 1);
    chk("p1_def_after", int'(dut.r_deficit[1]), 600);
    enter_reset();

    // Port 2: backpressure for 10 cycles, then async reset while a grant is offered.
    clear_cfg();
    set_port(2, 1'b1, 1000, 200);
    grant_ready = 1'b0;
    base = acc_cnt;
    release_rst();
    wait_valid(n);
    chk("p2_first_edges", n, 4);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("hold_valid", int'(grant_valid), 1);
      chk("hold_port", int'(grant_port), 2);
      chk("hold_bytes", int'(grant_bytes), 200);
      chk("hold_deficit", int'(dut.r_deficit[2]), 1000);
    end
    push_exp(2, 200);
    grant_ready = 1'b1;
    wait_acc(base + 1);
    grant_ready = 1'b0;
    chk("single_decrement", int'(dut.r_deficit[2]), 800);
    wait_valid(n);
    chk("p2_regrant_edges", n, 2);
    #2 areset = 1'b1;
    #1;
    chk("async_rst_valid", int'(grant_valid), 0);
    chk("async_rst_port", int'(grant_port), 0);
    chk("async_rst_bytes", int'(grant_bytes), 0);
    chk("async_rst_deficit2", int'(dut.r_deficit[2]), 0);
    chk("async_rst_cnt_zero", int'(grant_cnt == '0), 1);
    repeat (2) @(posedge clk);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
